// File: rtl/serial_tx_scheduler.sv
// Round-robin scheduler that hands one character at a time from two requesters
// to a serial transmitter, with a load timeout and a fixed inter-frame gap.
//
// state | meaning
// IDLE  | waiting for a request; arbitrates and latches the frame
// LOAD  | tx_enable high until the transmitter latches the frame or timeout
// SEND  | waiting for the transmitter to finish shifting
// GAP   | fixed idle spacing before the next arbitration
module serial_tx_scheduler #(
   parameter int unsigned LOAD_TIMEOUT = 1024,
   parameter int unsigned GAP_CYCLES   = 16
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       req0,
   input  logic [7:0] data0,
   input  logic       req1,
   input  logic [7:0] data1,
   output logic       ack0,
   output logic       ack1,
   output logic [9:0] tx_frame,
   output logic       tx_enable,
   input  logic       tx_load,
   input  logic       tx_sent,
   output logic       busy,
   output logic       grant_id,
   output logic       err
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_SEND = 2'd2,
      ST_GAP  = 2'd3
   } state_t;

   localparam logic [15:0] TOUT_LAST = 16'(LOAD_TIMEOUT - 1);
   localparam logic [7:0]  GAP_LAST  = 8'(GAP_CYCLES - 1);

   state_t      state_q, state_d;
   logic [15:0] tout_cnt_q, tout_cnt_d;
   logic [7:0]  gap_cnt_q, gap_cnt_d;
   logic [9:0]  frame_q, frame_d;
   logic        grant_q, grant_d;
   logic        last_q, last_d;
   logic        ack0_q, ack0_d;
   logic        ack1_q, ack1_d;
   logic        err_q, err_d;
   logic        winner;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         tout_cnt_q <= '0;
         gap_cnt_q  <= '0;
         frame_q    <= 10'h3FF;
         grant_q    <= 1'b0;
         last_q     <= 1'b1;
         ack0_q     <= 1'b0;
         ack1_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         tout_cnt_q <= tout_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
         frame_q    <= frame_d;
         grant_q    <= grant_d;
         last_q     <= last_d;
         ack0_q     <= ack0_d;
         ack1_q     <= ack1_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      tout_cnt_d = tout_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      frame_d    = frame_q;
      grant_d    = grant_q;
      last_d     = last_q;
      ack0_d     = 1'b0;
      ack1_d     = 1'b0;
      err_d      = 1'b0;
      // On a tie the requester not served last wins; otherwise the lone requester.
      winner     = (req0 && req1) ? ~last_q : req1;
      case (state_q)
         ST_IDLE: begin
            if (req0 || req1) begin
               grant_d    = winner;
               frame_d    = {1'b1, (winner ? data1 : data0), 1'b0};
               tout_cnt_d = '0;
               state_d    = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (tx_load) begin
               state_d = ST_SEND;
            end else if (tout_cnt_q == TOUT_LAST) begin
               err_d     = 1'b1;
               last_d    = grant_q;
               gap_cnt_d = GAP_LAST;
               state_d   = ST_GAP;
            end else begin
               tout_cnt_d = tout_cnt_q + 16'd1;
            end
         end
         ST_SEND: begin
            if (tx_sent) begin
               ack0_d    = ~grant_q;
               ack1_d    = grant_q;
               last_d    = grant_q;
               gap_cnt_d = GAP_LAST;
               state_d   = ST_GAP;
            end
         end
         ST_GAP: begin
            if (gap_cnt_q == 8'd0) begin
               state_d = ST_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q - 8'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      tx_enable = (state_q == ST_LOAD);
      busy      = (state_q != ST_IDLE);
      tx_frame  = frame_q;
      grant_id  = grant_q;
      ack0      = ack0_q;
      ack1      = ack1_q;
      err       = err_q;
   end

endmodule

// File: tb/tb_serial_tx_scheduler.sv
// Randomized transfer-level bench for serial_tx_scheduler: predicts the winner,
// enable duration, ack/err pulses and gap length from the scheduling rules.
module tb_serial_tx_scheduler;

   localparam int LT  = 8;
   localparam int GAP = 16;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       req0, req1;
   logic [7:0] data0, data1;
   logic       ack0, ack1;
   logic [9:0] tx_frame;
   logic       tx_enable;
   logic       tx_load, tx_sent;
   logic       busy, grant_id, err;

   always #5 clk = ~clk;

   serial_tx_scheduler #(.LOAD_TIMEOUT(LT), .GAP_CYCLES(GAP)) dut (
      .clk(clk), .reset_n(reset_n),
      .req0(req0), .data0(data0), .req1(req1), .data1(data1),
      .ack0(ack0), .ack1(ack1), .tx_frame(tx_frame), .tx_enable(tx_enable),
      .tx_load(tx_load), .tx_sent(tx_sent),
      .busy(busy), .grant_id(grant_id), .err(err)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_outs(input string tag, input bit en, input bit bsy,
                           input bit a0, input bit a1, input bit e);
      chk({tag, "_en"},   32'(tx_enable), 32'(en));
      chk({tag, "_busy"}, 32'(busy),      32'(bsy));
      chk({tag, "_ack0"}, 32'(ack0),      32'(a0));
      chk({tag, "_ack1"}, 32'(ack1),      32'(a1));
      chk({tag, "_err"},  32'(err),       32'(e));
   endtask

   // Requester-side model: who is pending, with what character, and who was served last.
   bit         pend [2];
   logic [7:0] dat  [2];
   bit         last;

   task automatic drive_reqs();
      req0  = pend[0];
      req1  = pend[1];
      data0 = dat[0];
      data1 = dat[1];
   endtask

   initial begin
      bit         w;
      bit         timeout;
      bit         do_reset;
      int         ld, sd, n_en, r;
      logic [9:0] exp_frame;

      reset_n = 1'b0;
      tx_load = 1'b0;
      tx_sent = 1'b0;
      pend[0] = 1'b0; pend[1] = 1'b0;
      dat[0]  = 8'h00; dat[1] = 8'h00;
      last    = 1'b1;
      drive_reqs();
      repeat (3) @(negedge clk);
      chk_outs("rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("rst_frame", 32'(tx_frame), 32'h3FF);
      chk("rst_grant", 32'(grant_id), 32'd0);
      reset_n = 1'b1;

      for (int it = 0; it < 60; it++) begin
         chk_outs("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         if (it == 0) begin
            pend[0] = 1'b1;
            dat[0]  = 8'hA5;
         end else begin
            for (int k = 0; k < 2; k++) begin
               if (!pend[k] && $urandom_range(0, 2) != 0) begin
                  pend[k] = 1'b1;
                  dat[k]  = 8'($urandom_range(0, 255));
               end
            end
            if (!pend[0] && !pend[1]) begin
               pend[it % 2] = 1'b1;
               dat[it % 2]  = 8'($urandom_range(0, 255));
            end
         end
         drive_reqs();

         w = (pend[0] && pend[1]) ? !last : pend[1];
         exp_frame = {1'b1, dat[w], 1'b0};
         if (it == 0) begin
            ld = 2;
            sd = 39;
         end else begin
            r = $urandom_range(0, 7);
            if (r == 0)      ld = LT + $urandom_range(0, 2);
            else if (r == 1) ld = LT - 1;
            else             ld = $urandom_range(0, 3);
            sd = $urandom_range(0, 6);
         end
         timeout = (ld >= LT);
         n_en    = timeout ? LT : ld + 1;

         for (int i = 0; i < n_en; i++) begin
            @(negedge clk);
            chk_outs("load", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            chk("load_grant", 32'(grant_id), 32'(w));
            chk("load_frame", 32'(tx_frame), 32'(exp_frame));
            tx_load = (i == ld);
            tx_sent = (i != ld) && ($urandom_range(0, 3) == 0);
         end
         @(negedge clk);
         tx_load = 1'b0;
         tx_sent = 1'b0;

         if (timeout) begin
            chk_outs("tout", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
            last = w;
         end else begin
            chk_outs("send", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            do_reset = (it > 2) && ($urandom_range(0, 9) == 0);
            for (int i = 0; i < sd; i++) begin
               if (pend[w] && $urandom_range(0, 5) == 0) begin
                  pend[w] = 1'b0;
                  drive_reqs();
               end
               @(negedge clk);
               chk_outs("sendw", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
               chk("send_grant", 32'(grant_id), 32'(w));
            end
            if (do_reset) begin
               reset_n = 1'b0;
               #1;
               chk_outs("arst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
               chk("arst_frame", 32'(tx_frame), 32'h3FF);
               #2;
               reset_n = 1'b1;
               last = 1'b1;
               continue;
            end
            tx_sent = 1'b1;
            @(negedge clk);
            tx_sent = 1'b0;
            chk_outs("ack", 1'b0, 1'b1, (w == 1'b0), (w == 1'b1), 1'b0);
            last = w;
            if (pend[w] && $urandom_range(0, 3) != 0) pend[w] = 1'b0;
            drive_reqs();
         end

         repeat (GAP - 1) begin
            @(negedge clk);
            chk_outs("gap", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
         end
         @(negedge clk);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_tx_scheduler.md
SERIAL_TX_SCHEDULER -- requirements
Module: serial_tx_scheduler

Interface
REQ-001 Parameter LOAD_TIMEOUT, default 1024: max cycles tx_enable may stay high without tx_load before the request is aborted; legal range 2..65535.
REQ-002 Parameter GAP_CYCLES, default 16: idle cycles forced between consecutive frames; legal range 1..255.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 req0  input  1  requester 0 (processor path) wants to send; level, held until ack0.
REQ-006 data0  input  8  requester 0 character; stable while req0 high.
REQ-007 req1  input  1  requester 1 (receive-echo path) wants to send; level, held until ack1.
REQ-008 data1  input  8  requester 1 character; stable while req1 high.
REQ-009 ack0 / ack1  output  1 each  one-cycle pulse: granted character fully transmitted.
REQ-010 tx_frame  output  10  frame to the transmitter: bit0 start=0, bits8:1 data LSB first, bit9 stop=1.
REQ-011 tx_enable  output  1  asks the transmitter to load tx_frame.
REQ-012 tx_load  input  1  transmitter has latched tx_frame.
REQ-013 tx_sent  input  1  transmitter finished shifting the frame.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 grant_id  output  1  requester owning the current transfer; valid while busy.
REQ-016 err  output  1  one-cycle pulse on load timeout.

Function
REQ-017 The block SHALL implement states IDLE, LOAD, SEND, GAP.
REQ-018 IDLE: if any req is high, SHALL select a winner, latch its data into tx_frame, set grant_id, clear the timeout counter, and enter LOAD next cycle.
REQ-019 Arbitration SHALL be round-robin: if both req high, the requester not served last wins; after reset, requester 0 wins the first tie.
REQ-020 LOAD: tx_enable SHALL be 1 and the timeout counter SHALL increment each cycle.
REQ-021 LOAD with tx_load=1 SHALL enter SEND; tx_enable SHALL be 0 from the next cycle.
REQ-022 LOAD with counter = LOAD_TIMEOUT-1 and tx_load=0 SHALL pulse err, issue no ack, mark the granted requester as last-served, and enter GAP.
REQ-023 tx_load and the timeout in the same cycle: tx_load SHALL win; no err.
REQ-024 tx_sent while in LOAD or IDLE SHALL be ignored.
REQ-025 SEND: on tx_sent=1, SHALL pulse ack for grant_id for exactly one cycle, mark it last-served, and enter GAP.
REQ-026 GAP: SHALL hold for GAP_CYCLES cycles, then enter IDLE; requests are not sampled in GAP.
REQ-027 tx_frame and grant_id SHALL stay constant from the IDLE exit until the next IDLE exit.
REQ-028 A req that drops after being granted SHALL NOT abort the transfer; the ack is still issued.
REQ-029 A req still high in the cycle after its ack SHALL be treated as a new request.
REQ-030 Minimum latency, req rising in IDLE to tx_enable high: 1 cycle.

Reset
REQ-031 reset_n=0 SHALL immediately force state IDLE and tx_enable=0, ack0=0, ack1=0, err=0, busy=0, grant_id=0, tx_frame=10'h3FF, counters=0, last-served=requester 1.
REQ-032 Reset asserted mid-transfer SHALL discard the transfer with no ack and no err; after release, behaviour follows REQ-018 and REQ-019.

Verification
REQ-033 req0=1, data0=8'hA5; transmitter returns tx_load 3 cycles later and tx_sent 40 cycles after that -> tx_frame=10'h34A, tx_enable high 3 cycles, ack0 pulses once, then 16 idle cycles.
REQ-034 req0 and req1 both high continuously with an ideal transmitter -> grants alternate 0,1,0,1; no ack is given twice in a row to the same requester.
REQ-035 tx_load never asserted, LOAD_TIMEOUT=8 -> tx_enable high exactly 8 cycles, err pulses once, no ack, the other pending requester is served next.
REQ-036 tx_load asserted in the final timeout cycle -> SEND entered, no err.
REQ-037 reset_n pulsed low during SEND -> tx_enable=0 and busy=0 asynchronously, no ack; the next tie goes to requester 0.
REQ-038 req1 dropped during SEND -> ack1 still pulses on tx_sent; tx_sent injected during LOAD has no effect.
